// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode, funct, ALU and mux-select encodings
// plus the packed control bundle driven by mc_ctrl.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'h0,
    S_ID      = 4'h1,
    S_MEM_ADR = 4'h2,
    S_MEM_RD  = 4'h3,
    S_WB_LW   = 4'h4,
    S_MEM_WR  = 4'h5,
    S_EXE_R   = 4'h6,
    S_WB_R    = 4'h7,
    S_BEQ     = 4'h8,
    S_JMP     = 4'h9,
    S_EXE_I   = 4'hA,
    S_WB_I    = 4'hB
  } state_e;

  typedef enum logic [1:0] {
    AC_ADD,
    AC_SUB,
    AC_FUNCT,
    AC_IMM
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic       done;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction fields and memory ready in, datapath controls out.
// master = control unit, slave = datapath/memory side.
interface mc_ctrl_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       MemReady;
  logic       PCWrite;
  logic       Branch;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALU_Control;
  logic       Inst_done;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, MemReady,
    output PCWrite, Branch, PCSource, IorD,
    output MemRead, MemWrite, IRWrite,
    output RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, ALU_Control,
    output Inst_done, State
  );

  modport slave (
    output Opcode, Funct, MemReady,
    input  PCWrite, Branch, PCSource, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, ALU_Control,
    input  Inst_done, State
  );
endinterface

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: cls_i/opcode_i/funct_i -> alu_ctl_o, funct_valid_o.
// funct_valid_o reflects funct_i alone; only EXE_R acts on it.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctl_o,
  output logic       funct_valid_o
);

  logic [2:0] fn_ctl;
  logic [2:0] im_ctl;

  always_comb begin
    fn_ctl        = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  fn_ctl = ALU_ADD;
      FN_SUB:  fn_ctl = ALU_SUB;
      FN_AND:  fn_ctl = ALU_AND;
      FN_OR:   fn_ctl = ALU_OR;
      FN_SLT:  fn_ctl = ALU_SLT;
      FN_NOR:  fn_ctl = ALU_NOR;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    im_ctl = ALU_ADD;
    case (opcode_i)
      OP_ANDI: im_ctl = ALU_AND;
      OP_ORI:  im_ctl = ALU_OR;
      OP_SLTI: im_ctl = ALU_SLT;
      default: im_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_ctl_o = ALU_ADD;
    case (cls_i)
      AC_SUB:   alu_ctl_o = ALU_SUB;
      AC_FUNCT: alu_ctl_o = fn_ctl;
      AC_IMM:   alu_ctl_o = im_ctl;
      default:  alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS Moore control FSM. clk, rst (async high);
// bus (mc_ctrl_if.master). Optional macro: MC_CTRL_MEM_WAIT_EN.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
);

  state_e     state_q, state_d;
  alu_cls_e   cls;
  ctl_t       ctl, ctl_o;
  logic [2:0] alu_ctl;
  logic       funct_ok;
  logic       rdy;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign rdy = bus.MemReady;
`else
  logic unused_ready;
  assign unused_ready = bus.MemReady;
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // ALU class depends on state only, keeping the decoder
  // outside the next-state block.
  always_comb begin
    cls = AC_ADD;
    case (state_q)
      S_EXE_R: cls = AC_FUNCT;
      S_EXE_I: cls = AC_IMM;
      S_BEQ:   cls = AC_SUB;
      default: cls = AC_ADD;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .cls_i         (cls),
    .opcode_i      (bus.Opcode),
    .funct_i       (bus.Funct),
    .alu_ctl_o     (alu_ctl),
    .funct_valid_o (funct_ok)
  );

  always_comb begin
    ctl     = '0;
    ctl.alu = alu_ctl;
    state_d = state_q;
    case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = rdy;
        ctl.pc_write = rdy;
        ctl.src_b    = SRCB_4;
        ctl.pc_src   = PCS_ALU;
        state_d      = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        ctl.src_b = SRCB_IMM2;
        case (bus.Opcode)
          OP_RTYPE: state_d = S_EXE_R;
          OP_LW,
          OP_SW:    state_d = S_MEM_ADR;
          OP_BEQ:   state_d = S_BEQ;
          OP_J:     state_d = S_JMP;
          OP_ADDI,
          OP_ANDI,
          OP_ORI,
          OP_SLTI:  state_d = S_EXE_I;
          default: begin
            state_d  = S_IF;
            ctl.done = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        ctl.src_a = 1'b1;
        ctl.src_b = SRCB_IMM;
        // Opcode is held stable from IF until the next IF
        state_d   = (bus.Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        state_d      = rdy ? S_WB_LW : S_MEM_RD;
      end
      S_WB_LW: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.done       = 1'b1;
        state_d        = S_IF;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        ctl.done      = rdy;
        state_d       = rdy ? S_IF : S_MEM_WR;
      end
      S_EXE_R: begin
        ctl.src_a = 1'b1;
        ctl.src_b = SRCB_B;
        if (funct_ok) begin
          state_d = S_WB_R;
        end else begin
          state_d  = S_IF;
          ctl.done = 1'b1;
        end
      end
      S_WB_R: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        ctl.done      = 1'b1;
        state_d       = S_IF;
      end
      S_EXE_I: begin
        ctl.src_a = 1'b1;
        ctl.src_b = SRCB_IMM;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        ctl.reg_write = 1'b1;
        ctl.done      = 1'b1;
        state_d       = S_IF;
      end
      S_BEQ: begin
        ctl.src_a  = 1'b1;
        ctl.src_b  = SRCB_B;
        ctl.branch = 1'b1;
        ctl.pc_src = PCS_ALUOUT;
        ctl.done   = 1'b1;
        state_d    = S_IF;
      end
      S_JMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = PCS_JUMP;
        ctl.done     = 1'b1;
        state_d      = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Hold every strobe low while reset is asserted.
  assign ctl_o = rst ? '0 : ctl;

  assign bus.PCWrite     = ctl_o.pc_write;
  assign bus.Branch      = ctl_o.branch;
  assign bus.PCSource    = ctl_o.pc_src;
  assign bus.IorD        = ctl_o.iord;
  assign bus.MemRead     = ctl_o.mem_read;
  assign bus.MemWrite    = ctl_o.mem_write;
  assign bus.IRWrite     = ctl_o.ir_write;
  assign bus.RegDst      = ctl_o.reg_dst;
  assign bus.MemtoReg    = ctl_o.mem_to_reg;
  assign bus.RegWrite    = ctl_o.reg_write;
  assign bus.ALUSrcA     = ctl_o.src_a;
  assign bus.ALUSrcB     = ctl_o.src_b;
  assign bus.ALU_Control = ctl_o.alu;
  assign bus.Inst_done   = ctl_o.done;
  assign bus.State       = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed instruction sequences for mc_ctrl with
// hand-written control words per state.
module tb_mc_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {bus.PCWrite, bus.Branch, bus.PCSource,
                bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALU_Control, bus.Inst_done};

  function automatic logic [17:0] cw(
    input logic pcw, br, input logic [1:0] pcs,
    input logic iord, mr, mw, irw, rd, m2r, rw, sa,
    input logic [1:0] sb, input logic [2:0] alu,
    input logic done);
    return {pcw, br, pcs, iord, mr, mw, irw,
            rd, m2r, rw, sa, sb, alu, done};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic look(input string tag,
                      input logic [3:0] st,
                      input logic [17:0] c);
    chk({tag, ".state"}, {28'd0, bus.State}, {28'd0, st});
    chk({tag, ".ctl"}, {14'd0, obs}, {14'd0, c});
  endtask

  logic [17:0] c_if, c_id, c_nop, c_madr, c_mrd, c_wblw;
  logic [17:0] c_mwr, c_exr_sub, c_exr_bad, c_wbr;
  logic [17:0] c_exi_or, c_wbi, c_beq, c_jmp;

  initial begin
    n_chk = 0;
    n_err = 0;
    c_if      = cw(1,0,2'b00,0,1,0,1,0,0,0,0,2'b01,3'b010,0);
    c_id      = cw(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,3'b010,0);
    c_nop     = cw(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,3'b010,1);
    c_madr    = cw(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b010,0);
    c_mrd     = cw(0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,3'b010,0);
    c_wblw    = cw(0,0,2'b00,0,0,0,0,0,1,1,0,2'b00,3'b010,1);
    c_mwr     = cw(0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,3'b010,1);
    c_exr_sub = cw(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b110,0);
    c_exr_bad = cw(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b010,1);
    c_wbr     = cw(0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,3'b010,1);
    c_exi_or  = cw(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b001,0);
    c_wbi     = cw(0,0,2'b00,0,0,0,0,0,0,1,0,2'b00,3'b010,1);
    c_beq     = cw(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,3'b110,1);
    c_jmp     = cw(1,0,2'b10,0,0,0,0,0,0,0,0,2'b00,3'b010,1);

    rst = 1'b1;
    bus.MemReady = 1'b1;
    bus.Opcode = 6'b100011;
    bus.Funct = 6'b000000;
    #1;
    look("rst0", 4'h0, 18'd0);
    tick();
    tick();
    look("rst1", 4'h0, 18'd0);
    rst = 1'b0;
    #1;
    look("rel_if", 4'h0, c_if);

    // R-type sub
    bus.Opcode = 6'b000000;
    bus.Funct = 6'b100010;
    tick(); look("r_id", 4'h1, c_id);
    tick(); look("r_exe", 4'h6, c_exr_sub);
    tick(); look("r_wb", 4'h7, c_wbr);
    tick(); look("r_if", 4'h0, c_if);

    // lw
    bus.Opcode = 6'b100011;
    tick(); look("lw_id", 4'h1, c_id);
    tick(); look("lw_adr", 4'h2, c_madr);
    tick(); look("lw_rd", 4'h3, c_mrd);
    tick(); look("lw_wb", 4'h4, c_wblw);
    tick(); look("lw_if", 4'h0, c_if);

    // sw
    bus.Opcode = 6'b101011;
    tick(); look("sw_id", 4'h1, c_id);
    tick(); look("sw_adr", 4'h2, c_madr);
    tick(); look("sw_wr", 4'h5, c_mwr);
    tick(); look("sw_if", 4'h0, c_if);

    // beq
    bus.Opcode = 6'b000100;
    tick(); look("beq_id", 4'h1, c_id);
    tick(); look("beq_ex", 4'h8, c_beq);
    tick(); look("beq_if", 4'h0, c_if);

    // j
    bus.Opcode = 6'b000010;
    tick(); look("j_id", 4'h1, c_id);
    tick(); look("j_ex", 4'h9, c_jmp);
    tick(); look("j_if", 4'h0, c_if);

    // ori; opcode changed in WB_I must not matter
    bus.Opcode = 6'b001101;
    tick(); look("ori_id", 4'h1, c_id);
    tick(); look("ori_ex", 4'hA, c_exi_or);
    bus.Opcode = 6'b000100;
    tick(); look("ori_wb", 4'hB, c_wbi);
    tick(); look("ori_if", 4'h0, c_if);

    // unsupported opcode
    bus.Opcode = 6'b111111;
    tick(); look("nop_id", 4'h1, c_nop);
    tick(); look("nop_if", 4'h0, c_if);

    // unsupported funct
    bus.Opcode = 6'b000000;
    bus.Funct = 6'b000000;
    tick(); look("badf_id", 4'h1, c_id);
    tick(); look("badf_ex", 4'h6, c_exr_bad);
    tick(); look("badf_if", 4'h0, c_if);

    // reset mid lw (in MEM_RD)
    bus.Opcode = 6'b100011;
    tick(); tick(); tick();
    look("mr_rd", 4'h3, c_mrd);
    rst = 1'b1;
    #1;
    look("mr_rst", 4'h0, 18'd0);
    tick();
    look("mr_hold", 4'h0, 18'd0);
    rst = 1'b0;
    #1;
    look("mr_if", 4'h0, c_if);
    tick(); look("mr_id", 4'h1, c_id);
    tick(); look("mr_adr", 4'h2, c_madr);
    tick(); tick(); tick();
    look("mr_done", 4'h0, c_if);

`ifdef MC_CTRL_MEM_WAIT_EN
    // IF stalls without MemReady
    bus.MemReady = 1'b0;
    bus.Opcode = 6'b101011;
    #1;
    look("w_if0", 4'h0,
         cw(0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,3'b010,0));
    tick();
    look("w_if1", 4'h0,
         cw(0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,3'b010,0));
    bus.MemReady = 1'b1;
    #1;
    look("w_if2", 4'h0, c_if);
    tick(); look("w_id", 4'h1, c_id);
    bus.MemReady = 1'b0;
    tick(); look("w_adr", 4'h2, c_madr);
    for (int i = 0; i < 3; i++) begin
      tick();
      look("w_wr_wait", 4'h5,
           cw(0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,3'b010,0));
    end
    bus.MemReady = 1'b1;
    #1;
    look("w_wr_done", 4'h5, c_mwr);
    tick(); look("w_if", 4'h0, c_if);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
